// File: rtl/scoreboard_registers_if.sv
// -----------------------------------------------------------------------------
// scoreboard_registers_if
//
// Purpose : Bundles the read, issue, write-back and status signals that
//           connect decode/issue and write-back to the scoreboarded register
//           file.
//
// Parameters
//   WIDTH       data width of each register
//   DEPTH       number of registers (power of two)
//   READ_PORTS  number of combinational read ports
//   WRITE_PORTS number of write-back ports
//
// Signals (flattened multi-port buses, port k at [k*W +: W])
//   rs_tag      source tags                   (master -> slave)
//   rs_use      operand actually needed       (master -> slave)
//   rs_value    read data                     (slave -> master)
//   rs_pending  source has outstanding write  (slave -> master)
//   stall       any used source pending       (slave -> master)
//   issue_valid instruction with rd issuing   (master -> slave)
//   issue_rd    destination tag of issue      (master -> slave)
//   issue_ready issue can be accepted         (slave -> master)
//   wb_valid    write-back port active        (master -> slave)
//   wb_rd       write-back tags               (master -> slave)
//   wb_value    write-back data               (master -> slave)
//   flush       clear all pending state       (master -> slave)
//   busy_count  number of pending registers   (slave -> master)
//
// Modports: master = pipeline side, slave = register file.
// -----------------------------------------------------------------------------
interface scoreboard_registers_if #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 32,
   parameter int READ_PORTS  = 2,
   parameter int WRITE_PORTS = 2
);
   localparam int TAG_W = $clog2(DEPTH);

   logic [READ_PORTS*TAG_W-1:0]  rs_tag;
   logic [READ_PORTS-1:0]        rs_use;
   logic [READ_PORTS*WIDTH-1:0]  rs_value;
   logic [READ_PORTS-1:0]        rs_pending;
   logic                         stall;
   logic                         issue_valid;
   logic [TAG_W-1:0]             issue_rd;
   logic                         issue_ready;
   logic [WRITE_PORTS-1:0]       wb_valid;
   logic [WRITE_PORTS*TAG_W-1:0] wb_rd;
   logic [WRITE_PORTS*WIDTH-1:0] wb_value;
   logic                         flush;
   logic [TAG_W:0]               busy_count;

   modport master (
      output rs_tag, rs_use, issue_valid, issue_rd,
             wb_valid, wb_rd, wb_value, flush,
      input  rs_value, rs_pending, stall, issue_ready, busy_count
   );

   modport slave (
      input  rs_tag, rs_use, issue_valid, issue_rd,
             wb_valid, wb_rd, wb_value, flush,
      output rs_value, rs_pending, stall, issue_ready, busy_count
   );

endinterface

// File: rtl/scoreboard_registers.sv
// -----------------------------------------------------------------------------
// scoreboard_registers
//
// Purpose : Multi-ported register file with an integrated single-bit
//           write-back scoreboard. Reports per-read-port pending status and a
//           combined stall to the issue stage, refuses an issue that would
//           create a second outstanding producer for a register, and keeps a
//           running count of pending registers.
//
// Ports
//   clock    sole clock, rising edge
//   reset_n  asynchronous active-low reset (clears data, pending, count)
//   bus      scoreboard_registers_if.slave (read / issue / write-back / status)
//
// Configuration
//   REGISTERS_BYPASS_EN  when defined, a read whose tag matches an active
//                        nonzero write-back in the same cycle returns the
//                        write-back data and reports not pending. When
//                        undefined, reads see only the stored array and
//                        pending bit.
//
// Register 0 is hardwired to zero: it is never written and never pending.
// -----------------------------------------------------------------------------
module scoreboard_registers #(
   parameter  int WIDTH       = 32,
   parameter  int DEPTH       = 32,
   parameter  int READ_PORTS  = 2,
   parameter  int WRITE_PORTS = 2,
   localparam int TAG_W       = $clog2(DEPTH)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   scoreboard_registers_if.slave  bus
);

   // Count of set bits; used only on the small "cleared by write-back" mask
   // to size the counter decrement.
   function automatic logic [TAG_W:0] count_set(input logic [DEPTH-1:0] v);
      logic [TAG_W:0] n;
      n = '0;
      for (int k = 0; k < DEPTH; k++) begin
         n = n + {{TAG_W{1'b0}}, v[k]};
      end
      return n;
   endfunction

   // State
   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] pending;
   logic [TAG_W:0]   busy_count_q;

   // Unpacked views of the flattened port buses
   logic [TAG_W-1:0] rs_tag_a [READ_PORTS];
   logic [TAG_W-1:0] wb_tag_a [WRITE_PORTS];
   logic [WIDTH-1:0] wb_val_a [WRITE_PORTS];

   for (genvar g = 0; g < READ_PORTS; g++) begin : g_rs_unpack
      assign rs_tag_a[g] = bus.rs_tag[g*TAG_W +: TAG_W];
   end

   for (genvar g = 0; g < WRITE_PORTS; g++) begin : g_wb_unpack
      assign wb_tag_a[g] = bus.wb_rd[g*TAG_W +: TAG_W];
      assign wb_val_a[g] = bus.wb_value[g*WIDTH +: WIDTH];
   end

   // Scoreboard next-state
   logic [DEPTH-1:0] wb_clear;      // tags cleared by an active write-back
   logic [DEPTH-1:0] issue_set;     // tag set by the accepted issue
   logic [DEPTH-1:0] pending_next;
   logic             issue_wb_hit;  // issue tag is being written back now
   logic             issue_ready;
   logic             issue_accept;
   logic             issue_inc;
   logic [TAG_W:0]   wb_dec;
   logic [TAG_W:0]   busy_next;

   always_comb begin
      wb_clear     = '0;
      issue_wb_hit = 1'b0;
      for (int j = 0; j < WRITE_PORTS; j++) begin
         if (bus.wb_valid[j] && (wb_tag_a[j] != '0)) begin
            wb_clear[wb_tag_a[j]] = 1'b1;
         end
         if (bus.wb_valid[j] && (wb_tag_a[j] == bus.issue_rd)) begin
            issue_wb_hit = 1'b1;
         end
      end

      // A register being written back this cycle frees its single producer
      // slot, so a new producer may issue into it in the same cycle.
      issue_ready  = !pending[bus.issue_rd] || issue_wb_hit;
      issue_accept = bus.issue_valid && issue_ready && !bus.flush;

      issue_set = '0;
      if (issue_accept && (bus.issue_rd != '0)) begin
         issue_set[bus.issue_rd] = 1'b1;
      end

      // Issue is applied after write-back so the new producer wins.
      if (bus.flush) begin
         pending_next = '0;
      end else begin
         pending_next = (pending & ~wb_clear) | issue_set;
      end

      // Counter delta: +1 only when the issue turns a clear bit on; -1 per
      // distinct set bit cleared by write-back and not re-set by the issue.
      issue_inc = issue_accept && (bus.issue_rd != '0) && !pending[bus.issue_rd];
      wb_dec    = count_set(pending & wb_clear & ~issue_set);

      if (bus.flush) begin
         busy_next = '0;
      end else begin
         busy_next = busy_count_q + {{TAG_W{1'b0}}, issue_inc} - wb_dec;
      end
   end

   // State update; write-back ports are scanned in ascending order so the
   // highest-numbered port hitting a tag wins the data.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            regs[k] <= '0;
         end
         pending      <= '0;
         busy_count_q <= '0;
      end else begin
         for (int j = 0; j < WRITE_PORTS; j++) begin
            if (bus.wb_valid[j] && (wb_tag_a[j] != '0)) begin
               regs[wb_tag_a[j]] <= wb_val_a[j];
            end
         end
         pending      <= pending_next;
         busy_count_q <= busy_next;
      end
   end

   // Read ports
   logic [READ_PORTS*WIDTH-1:0] rd_value;
   logic [READ_PORTS-1:0]       rd_pending;

   always_comb begin
      rd_value   = '0;
      rd_pending = '0;
      for (int i = 0; i < READ_PORTS; i++) begin
         rd_value[i*WIDTH +: WIDTH] = regs[rs_tag_a[i]];
         rd_pending[i]              = pending[rs_tag_a[i]];
`ifdef REGISTERS_BYPASS_EN
         // Forward same-cycle write-back data; later ports override earlier.
         for (int j = 0; j < WRITE_PORTS; j++) begin
            if (bus.wb_valid[j] && (wb_tag_a[j] != '0) &&
                (wb_tag_a[j] == rs_tag_a[i])) begin
               rd_value[i*WIDTH +: WIDTH] = wb_val_a[j];
               rd_pending[i]              = 1'b0;
            end
         end
`endif
      end
   end

   assign bus.rs_value    = rd_value;
   assign bus.rs_pending  = rd_pending;
   assign bus.stall       = |(bus.rs_use & rd_pending);
   assign bus.issue_ready = issue_ready;
   assign bus.busy_count  = busy_count_q;

   // The running counter must track the number of set pending bits.
   busy_count_matches_pending : assert property (
      @(posedge clock) disable iff (!reset_n)
      32'(busy_count_q) == $countones(pending)
   );

endmodule

// File: tb/tb_scoreboard_registers.sv
// -----------------------------------------------------------------------------
// tb_scoreboard_registers
//
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model of the register file (plain arrays of values and pending
// flags, busy count taken as the number of pending flags).
// Honours REGISTERS_BYPASS_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_scoreboard_registers;

   localparam int W  = 32;
   localparam int D  = 32;
   localparam int RP = 2;
   localparam int WP = 2;
   localparam int TW = $clog2(D);

   logic clock;
   logic reset_n;

   scoreboard_registers_if #(.WIDTH(W), .DEPTH(D), .READ_PORTS(RP), .WRITE_PORTS(WP)) bus ();

   scoreboard_registers #(.WIDTH(W), .DEPTH(D), .READ_PORTS(RP), .WRITE_PORTS(WP)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int n_cmp = 0;
   int n_err = 0;

   // Reference model
   logic [W-1:0] m_regs [D];
   bit           m_pend [D];

   task automatic model_reset();
      for (int t = 0; t < D; t++) begin
         m_regs[t] = '0;
         m_pend[t] = 1'b0;
      end
   endtask

   function automatic int m_busy();
      int n = 0;
      for (int t = 0; t < D; t++) n += int'(m_pend[t]);
      return n;
   endfunction

   function automatic logic [TW-1:0] wb_tag(int j);
      return bus.wb_rd[j*TW +: TW];
   endfunction

   function automatic logic [W-1:0] exp_val(int i);
      logic [TW-1:0] t;
      logic [W-1:0]  v;
      t = bus.rs_tag[i*TW +: TW];
      v = m_regs[t];
`ifdef REGISTERS_BYPASS_EN
      for (int j = 0; j < WP; j++)
         if (bus.wb_valid[j] && wb_tag(j) != 0 && wb_tag(j) == t) v = bus.wb_value[j*W +: W];
`endif
      return v;
   endfunction

   function automatic bit exp_pend(int i);
      logic [TW-1:0] t;
      bit p;
      t = bus.rs_tag[i*TW +: TW];
      p = m_pend[t];
`ifdef REGISTERS_BYPASS_EN
      for (int j = 0; j < WP; j++)
         if (bus.wb_valid[j] && wb_tag(j) != 0 && wb_tag(j) == t) p = 1'b0;
`endif
      return p;
   endfunction

   function automatic bit exp_ready();
      bit r;
      r = !m_pend[bus.issue_rd];
      for (int j = 0; j < WP; j++)
         if (bus.wb_valid[j] && wb_tag(j) == bus.issue_rd) r = 1'b1;
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_comb();
      bit st;
      st = 1'b0;
      for (int i = 0; i < RP; i++) begin
         check($sformatf("rs_value%0d", i), 64'(bus.rs_value[i*W +: W]), 64'(exp_val(i)));
         check($sformatf("rs_pending%0d", i), 64'(bus.rs_pending[i]), 64'(exp_pend(i)));
         st = st | (bus.rs_use[i] & exp_pend(i));
      end
      check("stall", 64'(bus.stall), 64'(st));
      check("issue_ready", 64'(bus.issue_ready), 64'(exp_ready()));
   endtask

   // Called at a falling edge with inputs already driven: check the
   // combinational outputs, update the model, cross the rising edge and
   // check the busy count at the next falling edge.
   task automatic tick();
      bit clr [D];
      bit rdy;
      #1;
      check_comb();
      rdy = exp_ready();
      for (int t = 0; t < D; t++) clr[t] = 1'b0;
      for (int j = 0; j < WP; j++) begin
         if (bus.wb_valid[j] && wb_tag(j) != 0) begin
            m_regs[wb_tag(j)] = bus.wb_value[j*W +: W];
            clr[wb_tag(j)]    = 1'b1;
         end
      end
      if (bus.flush) begin
         for (int t = 0; t < D; t++) m_pend[t] = 1'b0;
      end else begin
         for (int t = 0; t < D; t++) if (clr[t]) m_pend[t] = 1'b0;
         if (bus.issue_valid && rdy && bus.issue_rd != 0) m_pend[bus.issue_rd] = 1'b1;
      end
      @(posedge clock);
      @(negedge clock);
      check("busy_count", 64'(bus.busy_count), 64'(m_busy()));
   endtask

   task automatic idle();
      bus.rs_tag      = '0;
      bus.rs_use      = '0;
      bus.issue_valid = 1'b0;
      bus.issue_rd    = '0;
      bus.wb_valid    = '0;
      bus.wb_rd       = '0;
      bus.wb_value    = '0;
      bus.flush       = 1'b0;
   endtask

   task automatic set_rs(input int i, input logic [TW-1:0] t, input logic u);
      bus.rs_tag[i*TW +: TW] = t;
      bus.rs_use[i]          = u;
   endtask

   task automatic set_wb(input int j, input logic [TW-1:0] t, input logic [W-1:0] v);
      bus.wb_valid[j]        = 1'b1;
      bus.wb_rd[j*TW +: TW]  = t;
      bus.wb_value[j*W +: W] = v;
   endtask

   task automatic set_issue(input logic [TW-1:0] t);
      bus.issue_valid = 1'b1;
      bus.issue_rd    = t;
   endtask

   bit bypass;

   initial begin
`ifdef REGISTERS_BYPASS_EN
      bypass = 1'b1;
`else
      bypass = 1'b0;
`endif
      model_reset();
      reset_n = 1'b0;
      idle();
      repeat (2) @(negedge clock);

      // Outputs while reset is held
      set_rs(0, 5'd5, 1'b1);
      set_rs(1, 5'd17, 1'b1);
      set_issue(5'd9);
      #1;
      check("rst_rs_value0", 64'(bus.rs_value[0 +: W]), 64'd0);
      check("rst_rs_value1", 64'(bus.rs_value[W +: W]), 64'd0);
      check("rst_rs_pending", 64'(bus.rs_pending), 64'd0);
      check("rst_stall", 64'(bus.stall), 64'd0);
      check("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
      check("rst_busy", 64'(bus.busy_count), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Write r5 and attempt a write to r0
      idle();
      set_wb(0, 5'd5, 32'hDEADBEEF);
      set_wb(1, 5'd0, 32'h00001234);
      tick();
      idle();
      set_rs(0, 5'd5, 1'b1);
      set_rs(1, 5'd0, 1'b1);
      #1;
      check("r5_read", 64'(bus.rs_value[0 +: W]), 64'hDEADBEEF);
      check("r0_read", 64'(bus.rs_value[W +: W]), 64'd0);
      tick();

      // Issue r7, then write it back
      idle();
      set_issue(5'd7);
      tick();
      idle();
      set_rs(0, 5'd7, 1'b1);
      #1;
      check("r7_pending", 64'(bus.rs_pending[0]), 64'd1);
      check("r7_stall", 64'(bus.stall), 64'd1);
      check("r7_busy", 64'(bus.busy_count), 64'd1);
      tick();
      idle();
      set_rs(0, 5'd7, 1'b1);
      set_wb(0, 5'd7, 32'h55);
      #1;
      check("r7_wb_stall", 64'(bus.stall), bypass ? 64'd0 : 64'd1);
      tick();
      idle();
      set_rs(0, 5'd7, 1'b1);
      #1;
      check("r7_after_stall", 64'(bus.stall), 64'd0);
      check("r7_after_val", 64'(bus.rs_value[0 +: W]), 64'h55);
      tick();

      // WAW on r3: refused without write-back, accepted with one
      idle();
      set_issue(5'd3);
      tick();
      idle();
      set_issue(5'd3);
      #1;
      check("r3_waw_ready", 64'(bus.issue_ready), 64'd0);
      tick();
      check("r3_waw_busy", 64'(bus.busy_count), 64'd1);
      idle();
      set_issue(5'd3);
      set_wb(1, 5'd3, 32'h33);
      #1;
      check("r3_wb_ready", 64'(bus.issue_ready), 64'd1);
      tick();
      idle();
      set_rs(0, 5'd3, 1'b0);
      #1;
      check("r3_still_pending", 64'(bus.rs_pending[0]), 64'd1);
      check("r3_busy", 64'(bus.busy_count), 64'd1);
      tick();

      // Two ports write r9 in the same cycle
      idle();
      set_issue(5'd9);
      tick();
      idle();
      set_wb(0, 5'd9, 32'hAAAA);
      set_wb(1, 5'd9, 32'hBBBB);
      tick();
      idle();
      set_rs(1, 5'd9, 1'b1);
      #1;
      check("r9_value", 64'(bus.rs_value[W +: W]), 64'hBBBB);
      check("r9_busy", 64'(bus.busy_count), 64'd1);
      tick();

      // Three issues, then flush with a concurrent issue
      idle();
      set_wb(0, 5'd3, 32'h0);
      tick();
      idle(); set_issue(5'd1); tick();
      idle(); set_issue(5'd2); tick();
      idle(); set_issue(5'd4); tick();
      check("three_busy", 64'(bus.busy_count), 64'd3);
      idle();
      bus.flush = 1'b1;
      set_issue(5'd6);
      tick();
      idle();
      set_rs(0, 5'd6, 1'b1);
      #1;
      check("flush_busy", 64'(bus.busy_count), 64'd0);
      check("flush_r6_pending", 64'(bus.rs_pending[0]), 64'd0);
      tick();

      // Asynchronous reset between edges with two registers pending
      idle(); set_issue(5'd10); tick();
      idle(); set_issue(5'd11); tick();
      check("pre_reset_busy", 64'(bus.busy_count), 64'd2);
      idle();
      set_rs(0, 5'd10, 1'b1);
      set_rs(1, 5'd5, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_busy", 64'(bus.busy_count), 64'd0);
      check("async_pending", 64'(bus.rs_pending), 64'd0);
      check("async_r10", 64'(bus.rs_value[0 +: W]), 64'd0);
      check("async_r5", 64'(bus.rs_value[W +: W]), 64'd0);
      model_reset();
      #1;
      reset_n = 1'b1;
      @(negedge clock);

      // Randomized traffic over a small tag range to force collisions
      for (int n = 0; n < 400; n++) begin
         idle();
         for (int i = 0; i < RP; i++)
            set_rs(i, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) != 0) set_issue(5'($urandom_range(0, 7)));
         for (int j = 0; j < WP; j++)
            if ($urandom_range(0, 2) == 0) set_wb(j, 5'($urandom_range(0, 7)), $urandom);
         bus.flush = ($urandom_range(0, 15) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/scoreboard_registers.md
# scoreboard_registers

Parametrised register file with an integrated write-back scoreboard for the 7-stage pipeline. Generalises the single-write, two-read register file to N read ports and M write-back ports. Tracks which destination registers have an issued-but-not-yet-written result, and reports per-port pending and stall status to the issue stage. Sits between decode/issue (read and issue side) and the write-back stage (write side).

## Interface
- `WIDTH`, 32: data width of each register.
- `DEPTH`, 32: number of registers; power of two; `TAG_W = $clog2(DEPTH)`.
- `READ_PORTS`, 2: number of combinational read ports.
- `WRITE_PORTS`, 2: number of write-back ports.

- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rs_tag`  in  READ_PORTS*TAG_W  flattened source tags; port i at [i*TAG_W +: TAG_W].
- `rs_use`  in  READ_PORTS  port i operand is actually needed this cycle.
- `rs_value`  out  READ_PORTS*WIDTH  flattened read data.
- `rs_pending`  out  READ_PORTS  source register i has an outstanding write.
- `stall`  out  1  OR over i of (`rs_use[i]` & `rs_pending[i]`).
- `issue_valid`  in  1  instruction with a destination is issuing.
- `issue_rd`  in  TAG_W  destination tag of issuing instruction.
- `issue_ready`  out  1  issue may be accepted this cycle (no WAW conflict).
- `wb_valid`  in  WRITE_PORTS  write-back port j active.
- `wb_rd`  in  WRITE_PORTS*TAG_W  flattened write-back tags.
- `wb_value`  in  WRITE_PORTS*WIDTH  flattened write-back data.
- `flush`  in  1  clear all pending state (jump or redirect).
- `busy_count`  out  TAG_W+1  number of registers currently pending.

## Operation
- Register 0 is hardwired to zero. Writes to tag 0 are dropped. An issue to tag 0 is accepted but never sets pending. `rs_pending` for tag 0 is always 0.
- Reads are combinational from the array: `rs_value[i] = regs[rs_tag[i]]`. `rs_pending[i] = pending[rs_tag[i]]`.
- Write-back: for each j with `wb_valid[j]` and nonzero tag, `regs[wb_rd[j]] <= wb_value[j]` and `pending[wb_rd[j]] <= 0`. When several ports hit the same tag in one cycle, the highest j wins the data. The pending bit clears once.
- Accepted issue: `issue_valid & issue_ready & !flush`. It sets `pending[issue_rd] <= 1`.
- `issue_ready = !pending[issue_rd] | (some wb_valid[j] with wb_rd[j]==issue_rd)`. This is a single-bit scoreboard: at most one outstanding producer per register.
- Same-cycle issue and write-back to the same tag: the write is performed, and pending ends at 1 (the new producer wins).
- Flush: all pending bits are cleared and `busy_count` goes to 0 at the edge. Any issue in the same cycle is discarded. Write-back data in the flush cycle is still written.
- `busy_count` is a registered counter, not recomputed by popcount. Next value = current + (accepted issue setting a previously-clear bit) − (number of distinct tags whose set pending bit is cleared by write-back and not re-set by issue).
- `busy_count` must always equal the popcount of `pending`. Verification checks this with an assertion.

## Timing
- Reset (asserted, asynchronous) forces all registers to 0, pending to 0, and `busy_count` to 0. Consequently `rs_value` = 0, `rs_pending` = 0, `stall` = 0, and `issue_ready` = 1 while `reset_n` is low.
- Read latency is 0 cycles (combinational).
- Write-back data becomes visible on the array after the edge.
- Pending is set at the edge following an accepted issue. A read of that tag in the next cycle sees `rs_pending` = 1.
- Reset asserted mid-operation discards all pending and in-flight state immediately. There is no partial write.

## Configuration
- `REGISTERS_BYPASS_EN` defined:
  - A read whose tag matches an active nonzero `wb_rd[j]` in the same cycle returns `wb_value[j]` (highest j wins) with `rs_pending[i]` = 0.
  - The consumer therefore stalls 0 extra cycles after write-back.
- `REGISTERS_BYPASS_EN` undefined:
  - Reads return the array value and the stored pending bit.
  - The consumer stalls through the write-back cycle, which adds one cycle.

## Test plan
- Reset, then write back 0xDEADBEEF to r5 via port 0 → next cycle `rs_tag[0]`=5 reads 0xDEADBEEF. A write of 0x1234 to r0 → r0 reads 0.
- Issue rd=7 → next cycle `rs_pending`=1, `stall`=1 with `rs_use`=1, `busy_count`=1. Write back r7=0x55 → `stall` drops the same cycle with bypass, one cycle later without.
- Issue r3 while r3 is pending with no write-back → `issue_ready`=0 and the count stays the same. Issue r3 while port 1 writes back r3 → accepted, r3 stays pending, `busy_count` unchanged.
- Ports 0 and 1 both write r9 (0xAAAA, 0xBBBB) → r9 = 0xBBBB, `busy_count` decremented by 1 only.
- Issue r1, r2, r4 over three cycles (`busy_count`=3), then `flush` together with `issue_valid` for r6 → `busy_count`=0 and r6 is not pending.
- Pulse `reset_n` low between clock edges with 2 registers pending → `busy_count`, all registers, and `rs_pending` read 0 immediately.
